// File: rtl/register_file_32.sv
// Eight-entry 32-bit operand register file (R1..R4, S1..S4) feeding the ALU.
// Two combinational read ports; one write function per clock applied to all enabled entries.

module register_file_32_cell #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        en,
    input  logic [2:0]  fun_sel,
    input  logic [31:0] din,
    output logic [31:0] q
);
    always_ff @(posedge Clock) begin
        if (Reset) begin
            q <= RESET_VALUE;
        end else if (en) begin
            case (fun_sel)
                3'b000:  q <= q - 32'd1;
                3'b001:  q <= q + 32'd1;
                3'b010:  q <= din;
                3'b011:  q <= 32'h0000_0000;
                3'b100:  q <= {24'h00_0000, din[7:0]};
                3'b101:  q <= {q[31:16], din[15:0]};
                3'b110:  q <= {q[23:0], din[7:0]};
                default: q <= {{16{din[15]}}, din[15:0]};
            endcase
        end
    end
endmodule

module register_file_32 #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
    parameter int          NUM_REGS    = 8,
    parameter int          REG_W       = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [REG_W-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [3:0]       RegSel,
    input  logic [3:0]       ScrSel,
    input  logic [2:0]       OutASel,
    input  logic [2:0]       OutBSel,
    output logic [REG_W-1:0] OutA,
    output logic [REG_W-1:0] OutB
);
    logic [NUM_REGS-1:0]            en_vec;
    logic [NUM_REGS-1:0][REG_W-1:0] regs;

    // Entry k uses the same index as the read-select code, so R1 (code 0) takes the MSB.
    assign en_vec = {RegSel, ScrSel};

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        register_file_32_cell #(
            .RESET_VALUE(RESET_VALUE)
        ) u_cell (
            .Clock  (Clock),
            .Reset  (Reset),
            .en     (en_vec[NUM_REGS-1-k]),
            .fun_sel(FunSel),
            .din    (I),
            .q      (regs[k])
        );
    end

    assign OutA = regs[OutASel];
    assign OutB = regs[OutBSel];
endmodule

// File: tb/tb_register_file_32.sv
// Directed plus randomized bench for register_file_32 against an array-based reference model.

module tb_register_file_32;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] I;
    logic [2:0]  FunSel, OutASel, OutBSel;
    logic [3:0]  RegSel, ScrSel;
    logic [31:0] OutA, OutB;

    logic [31:0] mdl [8];
    bit          mdl_valid = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 Clock = ~Clock;

    register_file_32 dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .I      (I),
        .FunSel (FunSel),
        .RegSel (RegSel),
        .ScrSel (ScrSel),
        .OutASel(OutASel),
        .OutBSel(OutBSel),
        .OutA   (OutA),
        .OutB   (OutB)
    );

    function automatic logic [31:0] apply_fun(input logic [31:0] q, input logic [2:0] fs,
                                              input logic [31:0] d);
        case (fs)
            3'd0:    return q - 32'd1;
            3'd1:    return q + 32'd1;
            3'd2:    return d;
            3'd3:    return 32'd0;
            3'd4:    return d & 32'h0000_00FF;
            3'd5:    return (q & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
            3'd6:    return (q << 8) | (d & 32'h0000_00FF);
            default: return 32'($signed(d[15:0]));
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reads(input string tag);
        for (int a = 0; a < 8; a++) begin
            OutASel = 3'(a);
            OutBSel = 3'(7 - a);
            #1;
            check({tag, "_A"}, OutA, mdl[a]);
            check({tag, "_B"}, OutB, mdl[7 - a]);
        end
    endtask

    task automatic read_at(input logic [2:0] sel, input string tag, input logic [31:0] exp);
        OutASel = sel;
        #1;
        check(tag, OutA, exp);
    endtask

    // One clock of stimulus; ports must show old values before the edge, new ones after.
    task automatic step(input logic rst, input logic [2:0] fs, input logic [3:0] rs,
                        input logic [3:0] ss, input logic [31:0] d);
        logic [7:0] m;
        Reset = rst; FunSel = fs; RegSel = rs; ScrSel = ss; I = d;
        #1;
        if (mdl_valid) begin
            check("pre_edge_A", OutA, mdl[OutASel]);
            check("pre_edge_B", OutB, mdl[OutBSel]);
        end
        @(posedge Clock);
        m = {rs, ss};
        if (rst) begin
            for (int k = 0; k < 8; k++) mdl[k] = 32'h0000_0000;
            mdl_valid = 1'b1;
        end else begin
            for (int k = 0; k < 8; k++)
                if (m[7 - k]) mdl[k] = apply_fun(mdl[k], fs, d);
        end
        @(negedge Clock);
        Reset = 1'b0; RegSel = 4'h0; ScrSel = 4'h0;
        #1;
        if (mdl_valid) begin
            check("post_edge_A", OutA, mdl[OutASel]);
            check("post_edge_B", OutB, mdl[OutBSel]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rmw_exp;
        Reset = 1'b0; I = '0; FunSel = '0; RegSel = '0; ScrSel = '0;
        OutASel = '0; OutBSel = '0;
        #2;

        // Reset and full read sweep
        step(1'b1, 3'd0, 4'h0, 4'h0, 32'h0);
        check_reads("reset_sweep");

        // Load R1 only
        step(1'b0, 3'b010, 4'b1000, 4'b0000, 32'h1234_5678);
        read_at(3'd0, "load_r1", 32'h1234_5678);
        check_reads("after_load");

        // R2 wrap-around
        step(1'b0, 3'b011, 4'b0100, 4'b0000, 32'hFFFF_FFFF);
        step(1'b0, 3'b000, 4'b0100, 4'b0000, 32'h0);
        read_at(3'd1, "wrap_dec", 32'hFFFF_FFFF);
        step(1'b0, 3'b001, 4'b0100, 4'b0000, 32'h0);
        read_at(3'd1, "wrap_inc", 32'h0000_0000);
        step(1'b0, 3'b001, 4'b0100, 4'b0000, 32'h0);
        read_at(3'd1, "inc_one", 32'h0000_0001);

        // Partial writes on S3
        step(1'b0, 3'b010, 4'b0000, 4'b0010, 32'hAABB_CCDD);
        step(1'b0, 3'b101, 4'b0000, 4'b0010, 32'h0000_1234);
        read_at(3'd6, "half_low", 32'hAABB_1234);
        step(1'b0, 3'b110, 4'b0000, 4'b0010, 32'h0000_00EE);
        read_at(3'd6, "byte_shift", 32'hBB12_34EE);
        step(1'b0, 3'b111, 4'b0000, 4'b0010, 32'h0000_8001);
        read_at(3'd6, "sign_ext", 32'hFFFF_8001);
        step(1'b0, 3'b100, 4'b0000, 4'b0010, 32'hFFFF_FF7F);
        read_at(3'd6, "byte_zext", 32'h0000_007F);

        // Multi-enable increment with no bypass
        step(1'b0, 3'b010, 4'b1000, 4'b0000, 32'd5);
        step(1'b0, 3'b010, 4'b0000, 4'b0001, 32'd9);
        OutASel = 3'd0; OutBSel = 3'd7;
        #1;
        check("multi_pre_A", OutA, 32'd5);
        check("multi_pre_B", OutB, 32'd9);
        step(1'b0, 3'b001, 4'b1000, 4'b0001, 32'h0);
        check("multi_post_A", OutA, 32'd6);
        check("multi_post_B", OutB, 32'd10);

        // Same-cycle read-modify-write through the A port
        OutASel = 3'd0;
        #1;
        rmw_exp = mdl[0] ^ 32'h5A5A_0000;
        step(1'b0, 3'b010, 4'b1000, 4'b0000, OutA ^ 32'h5A5A_0000);
        read_at(3'd0, "rmw", rmw_exp);

        // Reset beats a simultaneous write; next load accepted
        step(1'b1, 3'b010, 4'b1111, 4'b1111, 32'hDEAD_BEEF);
        check_reads("reset_vs_write");
        step(1'b0, 3'b010, 4'b0010, 4'b0000, 32'hCAFE_F00D);
        read_at(3'd2, "load_after_reset", 32'hCAFE_F00D);

        // Reset between byte shifts discards the partial value
        step(1'b0, 3'b110, 4'b0000, 4'b1000, 32'h0000_0011);
        step(1'b0, 3'b110, 4'b0000, 4'b1000, 32'h0000_0022);
        step(1'b1, 3'b110, 4'b0000, 4'b1000, 32'h0000_0033);
        step(1'b0, 3'b110, 4'b0000, 4'b1000, 32'h0000_0044);
        read_at(3'd4, "shift_after_reset", 32'h0000_0044);

        // No enables: nothing changes whatever FunSel is
        for (int f = 0; f < 8; f++) step(1'b0, 3'(f), 4'h0, 4'h0, 32'hFFFF_FFFF);
        check_reads("no_enable");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            OutASel = 3'($urandom_range(0, 7));
            OutBSel = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 31) == 0), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
        end
        check_reads("final_sweep");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
